// File: rtl/sram_like_arbiter.sv
// N-channel sram-like master merger: arbitrates requests onto one slave port and
// routes returns in order via a FIFO of channel IDs. Define SRAM_LIKE_ARBITER_FIXED_PRIO_EN for fixed priority.
module sram_like_arbiter #(
  parameter int N_CH    = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MAX_OUT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CH-1:0]      m_req,
  input  logic [N_CH-1:0]      m_wr,
  input  logic [2*N_CH-1:0]    m_size,
  input  logic [AW*N_CH-1:0]   m_addr,
  input  logic [DW*N_CH-1:0]   m_wdata,
  output logic [N_CH-1:0]      m_addr_ok,
  output logic [N_CH-1:0]      m_data_ok,
  output logic [DW-1:0]        m_rdata,
  output logic                 s_req,
  output logic                 s_wr,
  output logic [1:0]           s_size,
  output logic [AW-1:0]        s_addr,
  output logic [DW-1:0]        s_wdata,
  input  logic                 s_addr_ok,
  input  logic                 s_data_ok,
  input  logic [DW-1:0]        s_rdata,
  output logic                 busy,
  output logic                 err_spurious
);

  localparam int IDW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int PW  = $clog2(MAX_OUT);
  localparam int CW  = PW + 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ISSUE = 1'b1;

  logic [0:0]     state_q, state_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic           wr_q, wr_d;
  logic [1:0]     size_q, size_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [DW-1:0]  wdata_q, wdata_d;
  logic [IDW-1:0] fifo_q [MAX_OUT];
  logic [IDW-1:0] fifo_d [MAX_OUT];
  logic [PW-1:0]  wptr_q, wptr_d;
  logic [PW-1:0]  rptr_q, rptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           err_q, err_d;

  logic           push_s;
  logic           pop_s;
  logic           arb_go_s;
  logic [IDW-1:0] win_s;
  logic [IDW-1:0] head_s;
  logic           sel_wr_s;
  logic [1:0]     sel_size_s;
  logic [AW-1:0]  sel_addr_s;
  logic [DW-1:0]  sel_wdata_s;

`ifdef SRAM_LIKE_ARBITER_FIXED_PRIO_EN
  logic           lo_found_s;

  // Fixed priority: lowest asserted index wins.
  always_comb begin
    lo_found_s = 1'b0;
    win_s      = '0;
    for (int j = 0; j < N_CH; j++) begin
      if (m_req[j] && !lo_found_s) begin
        lo_found_s = 1'b1;
        win_s      = IDW'(j);
      end else begin
        lo_found_s = lo_found_s;
      end
    end
  end
`else
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic           hi_found_s, lo_found_s;
  logic [IDW-1:0] hi_win_s, lo_win_s;

  // Round robin: channels above the last grant first, then wrap to the bottom.
  always_comb begin
    hi_found_s = 1'b0;
    lo_found_s = 1'b0;
    hi_win_s   = '0;
    lo_win_s   = '0;
    for (int j = 0; j < N_CH; j++) begin
      if (m_req[j] && (j > int'(rr_ptr_q)) && !hi_found_s) begin
        hi_found_s = 1'b1;
        hi_win_s   = IDW'(j);
      end else begin
        hi_found_s = hi_found_s;
      end
    end
    for (int j = 0; j < N_CH; j++) begin
      if (m_req[j] && (j <= int'(rr_ptr_q)) && !lo_found_s) begin
        lo_found_s = 1'b1;
        lo_win_s   = IDW'(j);
      end else begin
        lo_found_s = lo_found_s;
      end
    end
    if (hi_found_s) begin
      win_s = hi_win_s;
    end else begin
      win_s = lo_win_s;
    end
  end

  // Pointer remembers the last channel accepted by the slave.
  always_comb begin
    if (push_s) begin
      rr_ptr_d = grant_q;
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= IDW'(N_CH - 1);
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  // Select the winning channel's request fields.
  always_comb begin
    sel_wr_s    = 1'b0;
    sel_size_s  = 2'b00;
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    for (int j = 0; j < N_CH; j++) begin
      if (win_s == IDW'(j)) begin
        sel_wr_s    = m_wr[j];
        sel_size_s  = m_size[2*j +: 2];
        sel_addr_s  = m_addr[AW*j +: AW];
        sel_wdata_s = m_wdata[DW*j +: DW];
      end else begin
        sel_wr_s    = sel_wr_s;
      end
    end
  end

  // Handshake qualifiers; a full FIFO blocks arbitration regardless of a same-cycle pop.
  always_comb begin
    push_s   = (state_q == S_ISSUE) && s_addr_ok;
    pop_s    = s_data_ok && (count_q != '0);
    arb_go_s = (state_q == S_IDLE) && (|m_req) && (count_q < CW'(MAX_OUT));
    head_s   = fifo_q[rptr_q];
  end

  // Next state and latched request fields.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    wr_d    = wr_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (arb_go_s) begin
          state_d = S_ISSUE;
          grant_d = win_s;
          wr_d    = sel_wr_s;
          size_d  = sel_size_s;
          addr_d  = sel_addr_s;
          wdata_d = sel_wdata_s;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (s_addr_ok) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_ISSUE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Order FIFO bookkeeping and sticky spurious-return flag.
  always_comb begin
    fifo_d = fifo_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    count_d = count_q;
    if (push_s) begin
      fifo_d[wptr_q] = grant_q;
      wptr_d         = wptr_q + PW'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_s) begin
      rptr_d = rptr_q + PW'(1);
    end else begin
      rptr_d = rptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    err_d = err_q | (s_data_ok && (count_q == '0));
  end

  // State, request-field and FIFO registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      for (int k = 0; k < MAX_OUT; k++) begin
        fifo_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      err_q   <= err_d;
      fifo_q  <= fifo_d;
    end
  end

  // Slave-side outputs come from latched fields; master handshakes are combinational.
  always_comb begin
    s_req        = (state_q == S_ISSUE);
    s_wr         = wr_q;
    s_size       = size_q;
    s_addr       = addr_q;
    s_wdata      = wdata_q;
    busy         = (state_q == S_ISSUE) || (count_q != '0);
    err_spurious = err_q;
    m_rdata      = pop_s ? s_rdata : '0;
    for (int j = 0; j < N_CH; j++) begin
      m_addr_ok[j] = push_s && (grant_q == IDW'(j));
      m_data_ok[j] = pop_s && (head_s == IDW'(j));
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Scoreboard bench for sram_like_arbiter: stimulus pushes expected handshakes,
// a negedge monitor pops and compares whenever the DUT raises addr_ok/data_ok.
module tb_sram_like_arbiter;
  localparam int N_CH = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MAX_OUT = 4;

  logic clk = 1'b0;
  logic rst;
  logic [N_CH-1:0]    m_req, m_wr;
  logic [2*N_CH-1:0]  m_size;
  logic [AW*N_CH-1:0] m_addr;
  logic [DW*N_CH-1:0] m_wdata;
  logic [N_CH-1:0]    m_addr_ok, m_data_ok;
  logic [DW-1:0]      m_rdata;
  logic s_req, s_wr;
  logic [1:0] s_size;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic s_addr_ok, s_data_ok;
  logic [DW-1:0] s_rdata;
  logic busy, err_spurious;

  int n_chk = 0;
  int n_fail = 0;

  int            exp_gnt[$];
  logic [AW-1:0] exp_addr[$];
  logic [DW+2:0] exp_attr[$];
  int            exp_dch[$];
  logic [DW-1:0] exp_dval[$];

  sram_like_arbiter #(.N_CH(N_CH), .AW(AW), .DW(DW), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
    .busy(busy), .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic wr_of(input int ch);
    return (ch % 2) == 1;
  endfunction

  function automatic logic [1:0] size_of(input int ch);
    return ((ch % 2) == 1) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [DW-1:0] wd_of(input logic [AW-1:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Monitor: every handshake the DUT raises must match the head of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_addr_ok != '0) begin
        if (exp_gnt.size() == 0) begin
          chk("unexpected_addr_ok", 64'(m_addr_ok), 64'd0);
        end else begin
          chk("m_addr_ok", 64'(m_addr_ok), 64'(1) << exp_gnt.pop_front());
          chk("s_addr", 64'(s_addr), 64'(exp_addr.pop_front()));
          chk("s_attr", 64'({s_wr, s_size, s_wdata}), 64'(exp_attr.pop_front()));
        end
      end
      if (m_data_ok != '0) begin
        if (exp_dch.size() == 0) begin
          chk("unexpected_data_ok", 64'(m_data_ok), 64'd0);
        end else begin
          chk("m_data_ok", 64'(m_data_ok), 64'(1) << exp_dch.pop_front());
          chk("m_rdata", 64'(m_rdata), 64'(exp_dval.pop_front()));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [AW-1:0] a);
    m_addr[AW*ch +: AW]  = a;
    m_wr[ch]             = wr_of(ch);
    m_size[2*ch +: 2]    = size_of(ch);
    m_wdata[DW*ch +: DW] = wd_of(a);
  endtask

  task automatic expect_issue(input int ch, input logic [AW-1:0] a);
    exp_gnt.push_back(ch);
    exp_addr.push_back(a);
    exp_attr.push_back({wr_of(ch), size_of(ch), wd_of(a)});
  endtask

  task automatic expect_data(input int ch, input logic [DW-1:0] v);
    exp_dch.push_back(ch);
    exp_dval.push_back(v);
  endtask

  // One master request; master inputs are scrambled while ISSUE waits, slave accepts one cycle later.
  task automatic issue_one(input int ch, input logic [AW-1:0] a, input logic pop_too,
                           input logic [DW-1:0] pop_val, output int lat);
    set_ch(ch, a);
    expect_issue(ch, a);
    m_req = '0;
    m_req[ch] = 1'b1;
    lat = 0;
    do begin
      cyc();
      lat++;
    end while (!s_req && lat < 20);
    if (!s_req) chk("s_req_timeout", 64'(s_req), 64'd1);
    m_addr[AW*ch +: AW]  = ~a;
    m_wdata[DW*ch +: DW] = ~wd_of(a);
    s_addr_ok = 1'b1;
    if (pop_too) begin
      s_data_ok = 1'b1;
      s_rdata   = pop_val;
    end
    cyc();
    s_addr_ok = 1'b0;
    s_data_ok = 1'b0;
    m_req     = '0;
  endtask

  task automatic ret_data(input logic [DW-1:0] v);
    s_data_ok = 1'b1;
    s_rdata   = v;
    cyc();
    s_data_ok = 1'b0;
    s_rdata   = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s_req"}, 64'(s_req), 64'd0);
    chk({tag, "_s_wr"}, 64'(s_wr), 64'd0);
    chk({tag, "_s_size"}, 64'(s_size), 64'd0);
    chk({tag, "_s_addr"}, 64'(s_addr), 64'd0);
    chk({tag, "_s_wdata"}, 64'(s_wdata), 64'd0);
    chk({tag, "_m_addr_ok"}, 64'(m_addr_ok), 64'd0);
    chk({tag, "_m_data_ok"}, 64'(m_data_ok), 64'd0);
    chk({tag, "_m_rdata"}, 64'(m_rdata), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_err"}, 64'(err_spurious), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int gseq[4];
`ifdef SRAM_LIKE_ARBITER_FIXED_PRIO_EN
    gseq = '{0, 0, 0, 0};
`else
    gseq = '{0, 1, 0, 1};
`endif
    rst = 1'b1;
    m_req = '0; m_wr = '0; m_size = '0; m_addr = '0; m_wdata = '0;
    s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = '0;
    repeat (2) cyc();
    chk_all_zero("reset");
    rst = 1'b0;
    cyc();

    // Single channel.
    issue_one(0, 32'h0000_1000, 1'b0, '0, lat);
    chk("single_latency", 64'(lat), 64'd1);
    chk("single_busy_out", 64'(busy), 64'd1);
    cyc();
    expect_data(0, 32'hDEAD_BEEF);
    s_data_ok = 1'b1;
    s_rdata   = 32'hDEAD_BEEF;
    #1 chk("single_busy_dok", 64'(busy), 64'd1);
    cyc();
    s_data_ok = 1'b0;
    chk("single_busy_done", 64'(busy), 64'd0);

    // Round robin from a fresh reset, running into a full FIFO.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    set_ch(0, 32'h0000_0100);
    set_ch(1, 32'h0000_0200);
    for (int i = 0; i < 4; i++) expect_issue(gseq[i], (gseq[i] == 0) ? 32'h100 : 32'h200);
    m_req = 2'b11;
    s_addr_ok = 1'b1;
    repeat (8) cyc();
    s_addr_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("full_s_req", 64'(s_req), 64'd0);
      chk("full_busy", 64'(busy), 64'd1);
    end
    expect_data(gseq[0], 32'h0000_00A0);
    ret_data(32'h0000_00A0);
    chk("pop_s_req_1", 64'(s_req), 64'd0);
    cyc();
    chk("pop_s_req_2", 64'(s_req), 64'd1);
    expect_issue(0, 32'h0000_0100);
    s_addr_ok = 1'b1;
    cyc();
    s_addr_ok = 1'b0;
    m_req = '0;
    for (int i = 1; i < 4; i++) expect_data(gseq[i], 32'(32'hA0 + i));
    expect_data(0, 32'h0000_00A4);
    for (int i = 1; i <= 4; i++) ret_data(32'(32'hA0 + i));
    chk("rr_drain_busy", 64'(busy), 64'd0);

    // Order routing.
    issue_one(1, 32'h0000_3000, 1'b0, '0, lat);
    issue_one(0, 32'h0000_3004, 1'b0, '0, lat);
    issue_one(1, 32'h0000_3008, 1'b0, '0, lat);
    expect_data(1, 32'h11);
    expect_data(0, 32'h22);
    expect_data(1, 32'h33);
    ret_data(32'h11);
    ret_data(32'h22);
    ret_data(32'h33);
    chk("order_busy", 64'(busy), 64'd0);

    // Same-cycle push and pop on the same channel.
    issue_one(0, 32'h0000_4000, 1'b0, '0, lat);
    expect_data(0, 32'h44);
    issue_one(0, 32'h0000_4004, 1'b1, 32'h44, lat);
    chk("pushpop_busy", 64'(busy), 64'd1);
    expect_data(0, 32'h55);
    ret_data(32'h55);
    chk("pushpop_busy_done", 64'(busy), 64'd0);

    // Spurious return with nothing outstanding.
    chk("err_before", 64'(err_spurious), 64'd0);
    s_data_ok = 1'b1;
    s_rdata   = 32'h99;
    #1 chk("spur_m_data_ok", 64'(m_data_ok), 64'd0);
    chk("spur_m_rdata", 64'(m_rdata), 64'd0);
    cyc();
    s_data_ok = 1'b0;
    chk("spur_err", 64'(err_spurious), 64'd1);
    repeat (3) cyc();
    chk("spur_err_sticky", 64'(err_spurious), 64'd1);

    // Reset during ISSUE with two outstanding.
    issue_one(0, 32'h0000_5000, 1'b0, '0, lat);
    issue_one(1, 32'h0000_5004, 1'b0, '0, lat);
    set_ch(0, 32'h0000_5008);
    m_req = 2'b01;
    cyc();
    chk("pre_rst_s_req", 64'(s_req), 64'd1);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    m_req = '0;
    exp_gnt.delete(); exp_addr.delete(); exp_attr.delete();
    exp_dch.delete(); exp_dval.delete();
    cyc();
    rst = 1'b0;
    cyc();
    s_data_ok = 1'b1;
    s_rdata   = 32'h77;
    #1 chk("late_m_data_ok", 64'(m_data_ok), 64'd0);
    cyc();
    s_data_ok = 1'b0;
    chk("late_err", 64'(err_spurious), 64'd1);
    chk("late_busy", 64'(busy), 64'd0);
    issue_one(1, 32'h0000_6000, 1'b0, '0, lat);
    expect_data(1, 32'h66);
    ret_data(32'h66);
    cyc();

    chk("gnt_queue_empty", 64'(exp_gnt.size()), 64'd0);
    chk("data_queue_empty", 64'(exp_dch.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
